// File: rtl/dtc_pkg.sv
// Shared types and field helpers for the decision-tree stream engine.
// Optional class histogram is enabled by defining DTC_CLASS_HIST_EN.
package dtc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } state_t;

    localparam int HIST_W = 16;

    function automatic int feat_w(int in_w);
        return (in_w > 1) ? $clog2(in_w) : 1;
    endfunction

    function automatic int node_w(int in_w, int aw);
        return 1 + feat_w(in_w) + 2 * aw;
    endfunction

    function automatic int lo_off();
        return 0;
    endfunction

    function automatic int hi_off(int aw);
        return aw;
    endfunction

    function automatic int feat_off(int aw);
        return 2 * aw;
    endfunction

    function automatic int br_off(int in_w, int aw);
        return 2 * aw + feat_w(in_w);
    endfunction

    localparam int DEF_IN_W = 8;
    localparam int DEF_AW   = 6;
    localparam int DEF_FW   = feat_w(DEF_IN_W);

    typedef struct packed {
        logic              is_branch;
        logic [DEF_FW-1:0] feat;
        logic [DEF_AW-1:0] hi;
        logic [DEF_AW-1:0] lo;
    } node_t;

    function automatic node_t mk_node(
        logic              br,
        logic [DEF_FW-1:0] feat,
        logic [DEF_AW-1:0] hi,
        logic [DEF_AW-1:0] lo
    );
        node_t n;
        n.is_branch = br;
        n.feat      = feat;
        n.hi        = hi;
        n.lo        = lo;
        return n;
    endfunction

endpackage

// File: rtl/dtc_stream_engine_if.sv
// Config port plus feature-in / class-out valid/ready streams.
// Optional histogram ports (DTC_CLASS_HIST_EN) live on the top module.
interface dtc_stream_engine_if
    import dtc_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int CLS_W   = 2,
    parameter int NODE_AW = 6,
    parameter int NODE_W  = node_w(IN_W, NODE_AW)
);

    logic               cfg_we;
    logic [NODE_AW-1:0] cfg_addr;
    logic [NODE_W-1:0]  cfg_data;
    logic               cfg_ready;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic               out_valid;
    logic               out_ready;
    logic [CLS_W-1:0]   out_class;
    logic               out_err;
    logic [NODE_AW:0]   out_hops;

    modport master (
        output cfg_we, cfg_addr, cfg_data,
        input  cfg_ready,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_class, out_err, out_hops,
        output out_ready
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data,
        output cfg_ready,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_class, out_err, out_hops,
        input  out_ready
    );

endinterface

// File: rtl/dtc_node_table.sv
// Node table: register array, synchronous write and clear,
// combinational read of the node currently being walked.
module dtc_node_table #(
    parameter int AW = 6,
    parameter int W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    // Reset wipes the whole model; otherwise a single-entry write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dtc_stream_engine.sv
// Sequential table-driven decision-tree classifier, one node per cycle.
// Define DTC_CLASS_HIST_EN to add per-class 16-bit result counters.
module dtc_stream_engine
    import dtc_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int CLS_W    = 2,
    parameter int NODE_AW  = 6,
    parameter int MAX_HOPS = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef DTC_CLASS_HIST_EN
    input  logic                          hist_clr,
    output logic [2**CLS_W*HIST_W-1:0]    hist_flat,
`endif
    dtc_stream_engine_if.slave bus
);

    localparam int FW     = feat_w(IN_W);
    localparam int NODE_W = node_w(IN_W, NODE_AW);
    localparam int HW     = NODE_AW + 1;
    localparam logic [HW-1:0] MAXH = HW'(MAX_HOPS);

    state_t state;
    state_t state_n;

    logic [IN_W-1:0]    data_q;
    logic [NODE_AW-1:0] cur;
    logic [HW-1:0]      hops;
    logic [CLS_W-1:0]   cls_q;
    logic               err_q;
    logic [HW-1:0]      hops_q;

    logic [NODE_W-1:0]  node;
    logic               n_br;
    logic [FW-1:0]      n_feat;
    logic [NODE_AW-1:0] n_hi;
    logic [NODE_AW-1:0] n_lo;
    logic               bit_v;
    logic [NODE_AW-1:0] nxt;

    logic in_rdy;
    logic accept;
    logic wr_en;
    logic load;
    logic step;
    logic fin;
    logic fin_err;

    assign n_br   = node[br_off(IN_W, NODE_AW)];
    assign n_feat = node[feat_off(NODE_AW) +: FW];
    assign n_hi   = node[hi_off(NODE_AW) +: NODE_AW];
    assign n_lo   = node[lo_off() +: NODE_AW];

    // Feature select; indices beyond the vector read as 0.
    always_comb begin
        bit_v = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (n_feat == FW'(i)) begin
                bit_v = data_q[i];
            end
        end
    end

    assign nxt = bit_v ? n_hi : n_lo;

    // Config wins over a same-cycle vector; table frozen while busy.
    assign in_rdy = (state == IDLE) && !bus.cfg_we;
    assign accept = bus.in_valid && in_rdy;
    assign wr_en  = bus.cfg_we && (state == IDLE);

    dtc_node_table #(
        .AW (NODE_AW),
        .W  (NODE_W)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .raddr (cur),
        .rdata (node)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and datapath strobes.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        fin_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_n = WALK;
                end
            end
            WALK: begin
                if (!n_br) begin
                    fin     = 1'b1;
                    state_n = DONE;
                end else if (hops == MAXH) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                    state_n = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Walk registers and result capture; results hold through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cur    <= '0;
            hops   <= '0;
            cls_q  <= '0;
            err_q  <= 1'b0;
            hops_q <= '0;
        end else begin
            if (load) begin
                data_q <= bus.in_data;
                cur    <= '0;
                hops   <= '0;
            end
            if (step) begin
                cur  <= nxt;
                hops <= hops + 1'b1;
            end
            if (fin) begin
                cls_q  <= fin_err ? '0 : n_lo[CLS_W-1:0];
                err_q  <= fin_err;
                hops_q <= hops;
            end
        end
    end

    assign bus.cfg_ready = (state == IDLE);
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state == DONE);
    assign bus.out_class = cls_q;
    assign bus.out_err   = err_q;
    assign bus.out_hops  = hops_q;

`ifdef DTC_CLASS_HIST_EN
    logic [HIST_W-1:0] hist [2**CLS_W];

    // Saturating per-class count of good results; clear beats count.
    always_ff @(posedge clk) begin
        if (rst || hist_clr) begin
            for (int i = 0; i < 2**CLS_W; i++) begin
                hist[i] <= '0;
            end
        end else if ((state == DONE) && bus.out_ready && !err_q) begin
            if (hist[cls_q] != '1) begin
                hist[cls_q] <= hist[cls_q] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 2**CLS_W; g++) begin : g_hist
        assign hist_flat[g*HIST_W +: HIST_W] = hist[g];
    end
`endif

endmodule

// File: tb/tb_dtc_stream_engine.sv
// Directed bench for dtc_stream_engine with an expected-result queue.
// Histogram steps are compiled in when DTC_CLASS_HIST_EN is defined.
module tb_dtc_stream_engine;
    import dtc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dtc_stream_engine_if bus ();

`ifdef DTC_CLASS_HIST_EN
    logic        hist_clr = 1'b0;
    logic [63:0] hist_flat;
`endif

    dtc_stream_engine dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DTC_CLASS_HIST_EN
        .hist_clr  (hist_clr),
        .hist_flat (hist_flat),
`endif
        .bus       (bus.slave)
    );

    typedef struct {
        logic [1:0] cls;
        logic       err;
        logic [6:0] hops;
        int         lat;
    } exp_t;

    exp_t sb [$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int acc    = 0;
    bit hclr_hs = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outs(string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_class"}, 32'(bus.out_class), 32'd0);
        check({tag, "_out_err"},   32'(bus.out_err),   32'd0);
        check({tag, "_out_hops"},  32'(bus.out_hops),  32'd0);
    endtask

    task automatic cfg_write(logic [5:0] a, node_t d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic push(logic [1:0] c, logic e, logic [6:0] h, int l);
        exp_t x;
        x.cls  = c;
        x.err  = e;
        x.hops = h;
        x.lat  = l;
        sb.push_back(x);
    endtask

    task automatic start(logic [7:0] vec);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = vec;
        #1;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end
        acc = cyc + 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic recv(int stall);
        int t = 0;
        exp_t e;
        logic [1:0] c0;
        logic [6:0] h0;
        logic       e0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.out_valid) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("latency",   32'(cyc - acc),     32'(e.lat));
        check("out_class", 32'(bus.out_class), 32'(e.cls));
        check("out_err",   32'(bus.out_err),   32'(e.err));
        check("out_hops",  32'(bus.out_hops),  32'(e.hops));
        c0 = bus.out_class;
        h0 = bus.out_hops;
        e0 = bus.out_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid",    32'(bus.out_valid), 32'd1);
            check("stall_class",    32'(bus.out_class), 32'(c0));
            check("stall_hops",     32'(bus.out_hops),  32'(h0));
            check("stall_err",      32'(bus.out_err),   32'(e0));
            check("stall_in_ready", 32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
`ifdef DTC_CLASS_HIST_EN
        hist_clr = hclr_hs;
`endif
        @(negedge clk);
        bus.out_ready = 1'b0;
`ifdef DTC_CLASS_HIST_EN
        hist_clr = 1'b0;
`endif
        check("post_hs_valid",    32'(bus.out_valid), 32'd0);
        check("post_hs_in_ready", 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Three-node tree on feature 0.
        cfg_write(6'd0, mk_node(1'b1, 3'd0, 6'd2, 6'd1));
        cfg_write(6'd1, mk_node(1'b0, 3'd0, 6'd0, 6'd3));
        cfg_write(6'd2, mk_node(1'b0, 3'd0, 6'd0, 6'd1));
        push(2'd1, 1'b0, 7'd1, 2);
        start(8'h01);
        recv(0);
        push(2'd3, 1'b0, 7'd1, 2);
        start(8'h00);
        recv(0);

        // Depth-4 chain on features 2,1,7,3 with a stalled consumer.
        cfg_write(6'd0, mk_node(1'b1, 3'd2, 6'd3, 6'd1));
        cfg_write(6'd3, mk_node(1'b1, 3'd1, 6'd4, 6'd1));
        cfg_write(6'd4, mk_node(1'b1, 3'd7, 6'd5, 6'd1));
        cfg_write(6'd5, mk_node(1'b1, 3'd3, 6'd6, 6'd1));
        cfg_write(6'd6, mk_node(1'b0, 3'd0, 6'd0, 6'd2));
        push(2'd2, 1'b0, 7'd4, 5);
        start(8'h8E);
        recv(5);
        push(2'd3, 1'b0, 7'd4, 5);
        start(8'h86);
        recv(0);

        // Self-loop at the root ends on the hop limit.
        cfg_write(6'd0, mk_node(1'b1, 3'd0, 6'd0, 6'd0));
        push(2'd0, 1'b1, 7'd16, 17);
        start(8'hA5);
        recv(0);

        // Writes during a walk are dropped.
        cfg_write(6'd0, mk_node(1'b1, 3'd0, 6'd2, 6'd1));
        push(2'd1, 1'b0, 7'd1, 2);
        start(8'h01);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 6'd2;
        bus.cfg_data = mk_node(1'b0, 3'd0, 6'd0, 6'd2);
        #1;
        check("cfg_ready_walk", 32'(bus.cfg_ready), 32'd0);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        recv(0);
        push(2'd1, 1'b0, 7'd1, 2);
        start(8'h01);
        recv(0);

        // Config and vector together: write first, vector next cycle.
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 6'd2;
        bus.cfg_data = mk_node(1'b0, 3'd0, 6'd0, 6'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        #1;
        check("in_ready_cfg_prio", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        check("no_accept_on_cfg", 32'(bus.cfg_ready), 32'd1);
        push(2'd2, 1'b0, 7'd1, 2);
        start(8'h01);
        recv(0);

        // Reset in the middle of a long walk.
        cfg_write(6'd0, mk_node(1'b1, 3'd0, 6'd0, 6'd0));
        start(8'h00);
        repeat (3) begin
            check("pre_rst_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outs("mid_rst");
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        end
        push(2'd0, 1'b0, 7'd0, 1);
        start(8'hFF);
        recv(0);

`ifdef DTC_CLASS_HIST_EN
        hist_clr = 1'b1;
        @(negedge clk);
        hist_clr = 1'b0;
        check("hist_after_clr", 32'(hist_flat == 64'd0), 32'd1);
        cfg_write(6'd0, mk_node(1'b1, 3'd0, 6'd1, 6'd2));
        cfg_write(6'd1, mk_node(1'b0, 3'd0, 6'd0, 6'd1));
        cfg_write(6'd2, mk_node(1'b1, 3'd0, 6'd2, 6'd2));
        repeat (3) begin
            push(2'd1, 1'b0, 7'd1, 2);
            start(8'h01);
            recv(0);
        end
        push(2'd0, 1'b1, 7'd16, 17);
        start(8'h00);
        recv(0);
        check("hist0", 32'(hist_flat[15:0]),  32'd0);
        check("hist1", 32'(hist_flat[31:16]), 32'd3);
        check("hist2", 32'(hist_flat[47:32]), 32'd0);
        check("hist3", 32'(hist_flat[63:48]), 32'd0);
        hclr_hs = 1'b1;
        push(2'd1, 1'b0, 7'd1, 2);
        start(8'h01);
        recv(0);
        hclr_hs = 1'b0;
        check("hist_clr_prio", 32'(hist_flat == 64'd0), 32'd1);
`endif

        if (sb.size() != 0) begin
            check("scoreboard_drained", 32'(sb.size()), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
